// File: rtl/zest_spi_pkg.sv
// zest_spi_pkg
// Shared definitions for the P2 serial-bus sequencer: target encodings,
// frame and instruction lengths, the sequencer state enum and the helpers
// that turn a request into a left-aligned serial frame.
package zest_spi_pkg;

  // Target encodings on the 'target' request input
  localparam logic [1:0] TGT_U1 = 2'd0;  // LMK01801 clock distributor (uWire)
  localparam logic [1:0] TGT_U2 = 2'd1;  // AD9653 ADC
  localparam logic [1:0] TGT_U3 = 2'd2;  // AD9653 ADC
  localparam logic [1:0] TGT_U4 = 2'd3;  // AD9781 DAC

  // Frame lengths in bits
  localparam logic [5:0] FRAME_LEN_U1  = 6'd32;
  localparam logic [5:0] FRAME_LEN_ADC = 6'd24;
  localparam logic [5:0] FRAME_LEN_DAC = 6'd16;

  // Instruction lengths (R/W bit + width bits + address) before read data
  localparam logic [5:0] INSTR_LEN_ADC = 6'd16;
  localparam logic [5:0] INSTR_LEN_DAC = 6'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LATCH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Frame placed MSB-aligned in 32 bits so the shifter always sends bit 31.
  // rd is the effective read flag (already forced low for U1).
  function automatic logic [31:0] build_frame(input logic [1:0]  tgt,
                                              input logic        rd,
                                              input logic [12:0] addr,
                                              input logic [27:0] wdata);
    logic [31:0] f;
    case (tgt)
      TGT_U1:         f = {wdata, addr[3:0]};
      TGT_U2, TGT_U3: f = {rd, 2'b00, addr, wdata[7:0], 8'h00};
      TGT_U4:         f = {rd, 2'b00, addr[4:0], wdata[7:0], 16'h0000};
      default:        f = 32'h0000_0000;
    endcase
    return f;
  endfunction

  function automatic logic [5:0] frame_len(input logic [1:0] tgt);
    logic [5:0] n;
    case (tgt)
      TGT_U1:  n = FRAME_LEN_U1;
      TGT_U4:  n = FRAME_LEN_DAC;
      default: n = FRAME_LEN_ADC;
    endcase
    return n;
  endfunction

  function automatic logic [5:0] instr_len(input logic [1:0] tgt);
    logic [5:0] n;
    case (tgt)
      TGT_U4:  n = INSTR_LEN_DAC;
      default: n = INSTR_LEN_ADC;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/zest_spi_tick.sv
// zest_spi_tick
// Half-period timer for the serial sequencer: a CLK_DIV down-counter that
// pulses 'tick' every CLK_DIV cycles and restarts its count whenever the
// sequencer changes state, so every state begins with a full half-period.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   restart     reload the count this cycle (state entry)
//   tick        high in the last cycle of each CLK_DIV-cycle period
module zest_spi_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt_r;

  // Down-counter, reloaded on state entry or when it reaches zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= RELOAD;
    end else if (restart || (cnt_r == 8'd0)) begin
      cnt_r <= RELOAD;
    end else begin
      cnt_r <= cnt_r - 8'd1;
    end
  end

  assign tick = (cnt_r == 8'd0);

endmodule

// File: rtl/zest_spi_seq.sv
// zest_spi_seq
// Serial sequencer for the shared P2 bus: U1 (LMK01801, uWire with LE),
// U2/U3 (AD9653) and U4 (AD9781) on one SCLK / SDIO pair. A start in IDLE
// captures the request, then the frame is shifted out MSB first with
// 3-wire read turnaround for the ADC/DAC targets.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   start            request strobe, only honoured in IDLE
//   target, read     device select (0..3) and read request
//   addr, wdata      register address and write data
//   busy, done       transaction in progress / one-cycle completion pulse
//   rdata            last read result
//   sclk, sdo, sdi   serial clock, data out, data in
//   sdio_as_i        1 while the device owns SDIO
//   csb              per-target active-low chip selects (bit 0 unused)
//   le               U1 latch enable
module zest_spi_seq
  import zest_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  target,
  input  logic        read,
  input  logic [12:0] addr,
  input  logic [27:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        sclk,
  output logic        sdo,
  input  logic        sdi,
  output logic        sdio_as_i,
  output logic [3:0]  csb,
  output logic        le
);

  state_t      state_r, state_next_s;
  logic        tick_s, restart_s, accept_s;
  logic        rise_s, fall_s, last_half_s, turn_s;
  logic        rd_new_s;
  logic [31:0] frame_new_s;
  logic [1:0]  sel_tgt_s;

  logic [1:0]  tgt_r;
  logic        rd_r;
  logic [5:0]  nbits_r, ilen_r;
  logic [31:0] frame_r;
  logic [6:0]  half_r;   // half-periods completed in SHIFT
  logic [7:0]  rx_r;

  logic        busy_r, done_r, sclk_r, sdo_r, sdio_r, le_r;
  logic [7:0]  rdata_r;
  logic [3:0]  csb_r;
  logic        busy_s, done_s, sclk_s, sdo_s, sdio_s, le_s;
  logic [7:0]  rdata_s;
  logic [3:0]  csb_s;

  zest_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_s),
    .tick    (tick_s)
  );

  assign accept_s    = (state_r == ST_IDLE) && start;
  assign restart_s   = (state_next_s != state_r);
  // U1 has no read path, so a read request to it is sent as a write.
  assign rd_new_s    = read && (target != TGT_U1);
  assign frame_new_s = build_frame(target, rd_new_s, addr, wdata);
  // Chip select must assert in the accept cycle, before tgt_r is loaded.
  assign sel_tgt_s   = (state_r == ST_IDLE) ? target : tgt_r;

  // SHIFT starts with sclk low: even half-periods end in a rise, odd in a fall.
  assign rise_s      = (state_r == ST_SHIFT) && tick_s && !half_r[0];
  assign fall_s      = (state_r == ST_SHIFT) && tick_s &&  half_r[0];
  assign last_half_s = (half_r == ({nbits_r, 1'b0} - 7'd1));
  // Fall that completes the last instruction bit of a read.
  assign turn_s      = fall_s && rd_r && (half_r == ({ilen_r, 1'b0} - 7'd1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_SETUP;
        else       state_next_s = ST_IDLE;
      end
      ST_SETUP: begin
        if (tick_s) state_next_s = ST_SHIFT;
        else        state_next_s = ST_SETUP;
      end
      ST_SHIFT: begin
        if (fall_s && last_half_s) state_next_s = ST_HOLD;
        else                       state_next_s = ST_SHIFT;
      end
      ST_HOLD: begin
        if (tick_s) begin
          if (tgt_r == TGT_U1) state_next_s = ST_LATCH;
          else                 state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      ST_LATCH: begin
        if (tick_s) state_next_s = ST_DONE;
        else        state_next_s = ST_LATCH;
      end
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: next values for the registered bus outputs
  always_comb begin
    busy_s = (state_next_s != ST_IDLE);
    done_s = (state_next_s == ST_DONE);
    le_s   = (state_next_s == ST_LATCH);

    csb_s = 4'b1111;
    if (((state_next_s == ST_SETUP) || (state_next_s == ST_SHIFT) ||
         (state_next_s == ST_HOLD)) && (sel_tgt_s != TGT_U1)) begin
      csb_s[sel_tgt_s] = 1'b0;
    end else begin
      csb_s = 4'b1111;
    end

    if (state_next_s != ST_SHIFT) sclk_s = 1'b0;
    else if (rise_s)              sclk_s = 1'b1;
    else if (fall_s)              sclk_s = 1'b0;
    else                          sclk_s = sclk_r;

    // Once SDIO is handed to the device the FPGA side drives zeros.
    if (accept_s) begin
      sdo_s = frame_new_s[31];
    end else if ((state_next_s == ST_SETUP) || (state_next_s == ST_SHIFT)) begin
      if (fall_s) sdo_s = (sdio_r || turn_s) ? 1'b0 : frame_r[30];
      else        sdo_s = sdo_r;
    end else begin
      sdo_s = 1'b0;
    end

    if (state_next_s == ST_IDLE) sdio_s = 1'b0;
    else if (turn_s)             sdio_s = 1'b1;
    else                         sdio_s = sdio_r;

    if ((state_next_s == ST_DONE) && rd_r) rdata_s = rx_r;
    else                                   rdata_s = rdata_r;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      le_r    <= 1'b0;
      csb_r   <= 4'b1111;
      sclk_r  <= 1'b0;
      sdo_r   <= 1'b0;
      sdio_r  <= 1'b0;
      rdata_r <= 8'h00;
    end else begin
      busy_r  <= busy_s;
      done_r  <= done_s;
      le_r    <= le_s;
      csb_r   <= csb_s;
      sclk_r  <= sclk_s;
      sdo_r   <= sdo_s;
      sdio_r  <= sdio_s;
      rdata_r <= rdata_s;
    end
  end

  // Request capture, transmit shifter, half-period count and receive shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_r   <= 2'd0;
      rd_r    <= 1'b0;
      nbits_r <= 6'd0;
      ilen_r  <= 6'd0;
      frame_r <= 32'h0000_0000;
      half_r  <= 7'd0;
      rx_r    <= 8'h00;
    end else if (accept_s) begin
      tgt_r   <= target;
      rd_r    <= rd_new_s;
      nbits_r <= frame_len(target);
      ilen_r  <= instr_len(target);
      frame_r <= frame_new_s;
      half_r  <= 7'd0;
    end else if ((state_r == ST_SHIFT) && tick_s) begin
      half_r <= half_r + 7'd1;
      if (fall_s) frame_r <= {frame_r[30:0], 1'b0};
      else        frame_r <= frame_r;
      if (rise_s) rx_r <= {rx_r[6:0], sdi};
      else        rx_r <= rx_r;
    end else begin
      half_r  <= half_r;
      frame_r <= frame_r;
      rx_r    <= rx_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign rdata     = rdata_r;
  assign sclk      = sclk_r;
  assign sdo       = sdo_r;
  assign sdio_as_i = sdio_r;
  assign csb       = csb_r;
  assign le        = le_r;

endmodule

// File: doc/zest_spi_seq.md
ZEST_SPI_SEQ -- requirements
Module: zest_spi_seq

Interface
REQ-001 Parameter CLK_DIV, default 4, gives the SCLK half-period in clk cycles; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic is on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle request strobe; sampled only in IDLE.
REQ-005 target  input  2  0=U1 LMK01801, 1=U2 AD9653, 2=U3 AD9653, 3=U4 AD9781.
REQ-006 read  input  1  1 requests a read cycle; ignored when target is 0.
REQ-007 addr  input  13  register address; U4 uses addr[4:0] and U1 uses addr[3:0].
REQ-008 wdata  input  28  write data; U2, U3 and U4 use wdata[7:0].
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse at transaction end.
REQ-011 rdata  output  8  read result; holds its value until the next accepted read.
REQ-012 sclk  output  1  shared P2 serial clock; idles low.
REQ-013 sdo  output  1  serial data out, MSB first.
REQ-014 sdi  input  1  serial data in from the shared P2 SDIO line.
REQ-015 sdio_as_i  output  1  1 = FPGA releases SDIO, so the device drives it.
REQ-016 csb  output  4  per-target active-low chip select; bit 0 is unused and held high.
REQ-017 le  output  1  U1 uWire latch enable, active-high.

Function
REQ-018 State machine states: IDLE, SETUP, SHIFT, HOLD, LATCH, DONE.
REQ-019 IDLE with start=1: the block captures the inputs, forms the frame and enters SETUP next cycle; busy rises in that same cycle.
REQ-020 U1 frame: 32 bits, {wdata[27:0], addr[3:0]}.
REQ-021 U2/U3 frame: 24 bits, {read, 2'b00, addr[12:0], wdata[7:0]}.
REQ-022 U4 frame: 16 bits, {read, 2'b00, addr[4:0], wdata[7:0]}.
REQ-023 SETUP: the selected csb bit goes low, sdo presents the frame MSB and sclk stays low, for CLK_DIV cycles.
REQ-024 SHIFT: sclk toggles every CLK_DIV cycles.
REQ-025 SHIFT sdi sampling: sdi is sampled at each sclk rise.
REQ-026 SHIFT sdo update: sdo advances to the next bit at each sclk fall.
REQ-027 SHIFT exit: after the last rising edge plus CLK_DIV cycles, sclk returns low and the state becomes HOLD.
REQ-028 Read, turnaround: sdio_as_i rises at the sclk fall after the last instruction bit (bit 16 for U2/U3, bit 8 for U4).
REQ-029 Read, data bits: sdo is 0 while sdio_as_i is high.
REQ-030 Read, release: sdio_as_i returns low on entry to IDLE.
REQ-031 HOLD: sclk stays low for CLK_DIV cycles, then csb returns high.
REQ-032 HOLD exit: go to LATCH if target is 0, else to DONE.
REQ-033 LATCH (U1 only): le is high for CLK_DIV cycles, then the state becomes DONE.
REQ-034 DONE: done=1 for one cycle; for a read, rdata takes the last 8 sampled bits; the state returns to IDLE.
REQ-035 A start while busy is ignored with no side effect.
REQ-036 A start in the DONE cycle is ignored.
REQ-037 Read with target 0 is performed as a write; rdata is unchanged.
REQ-038 Only one csb bit or le is active at a time; sclk, sdo and le are 0 outside an active frame.
REQ-039 Total transaction length in clk cycles is (2*N+2)*CLK_DIV+2, N = frame bits; U1 adds CLK_DIV.

Reset
REQ-040 rst_n low asynchronously forces: state IDLE, busy=0, done=0, rdata=0, sclk=0, sdo=0, sdio_as_i=0, csb=4'b1111, le=0.
REQ-041 Reset during an active frame aborts it with no done pulse; the first start after rst_n rises is accepted normally.

Structure
REQ-042 Package zest_spi_pkg holds the target encodings, frame lengths (32/24/16), instruction lengths (16/8) and the state enum.
REQ-043 Sub-module zest_spi_tick is a CLK_DIV down-counter producing the half-period tick; it restarts on every state entry.

Verification
REQ-044 CLK_DIV=4, write U2 addr 13'h008 wdata 8'h03 -> csb[1] low; sdo frame 24'h000803; 24 sclk rises; done after 202 cycles.
REQ-045 Read U3 addr 13'h001 with a device model returning 8'h93 -> sdio_as_i rises after bit 16; rdata=8'h93 at done.
REQ-046 U1 write wdata 28'h0123456, addr 4'h5 -> frame 32'h01234565 on csb-free bus; le high 4 cycles after HOLD; csb stays 4'b1111.
REQ-047 U4 write addr 5'h02, wdata 8'hA5 -> frame 16'h02A5, csb[3] low; a start pulsed mid-frame is ignored.
REQ-048 rst_n asserted mid-SHIFT of a U2 read -> all outputs at reset values within the same cycle; no done pulse; the next write completes.
REQ-049 Read request to target 0 -> write-format frame; rdata keeps its prior value 8'h93.
